// File: rtl/control_unit.sv
// SAP-1 control sequencer: six-state ring counter clocked on the falling edge,
// an opcode latch captured at T3->T4, and a sticky halt flag. The control word
// is a pure combinational decode of ring state, latched opcode and halt flag.
module control_unit (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] opcode,
  output logic [5:0] T,
  output logic       Cp,
  output logic       Ep,
  output logic       nLm,
  output logic       nCE,
  output logic       nLi,
  output logic       nEi,
  output logic       nLa,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       nLb,
  output logic       nLo,
  output logic       HLT
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e   t_q, t_d;
  logic [3:0] op_q, op_d;
  logic       halted_q, halted_d;

  // The ring value is the observable FSM state.
  assign T = t_q;

  // State registers: falling-edge update so the control word settles half a
  // period before the datapath's rising edge; CLR overrides everything.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      t_q      <= T1;
      op_q     <= 4'h0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      op_q     <= op_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: rotate the ring unless halted; latch opcode and decide halt
  // on the T3->T4 edge so later IR changes cannot disturb the execute cycle.
  always_comb begin
    t_d      = t_q;
    op_d     = op_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (t_q)
        T1: t_d = T2;
        T2: t_d = T3;
        T3: begin
          t_d      = T4;
          op_d     = opcode;
          halted_d = (opcode == OP_HLT);
        end
        T4: t_d = T5;
        T5: t_d = T6;
        T6: t_d = T1;
        default: t_d = T1;
      endcase
    end
  end

  // Control word decode; every strobe starts at its inactive level.
  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    nLm = 1'b1;
    nCE = 1'b1;
    nLi = 1'b1;
    nEi = 1'b1;
    nLa = 1'b1;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    nLb = 1'b1;
    nLo = 1'b1;
    HLT = 1'b0;
    if (halted_q) begin
      HLT = 1'b1;
    end else begin
      case (t_q)
        T1: begin
          Ep  = 1'b1;
          nLm = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          nCE = 1'b0;
          nLi = 1'b0;
        end
        T4: begin
          case (op_q)
            OP_LDA, OP_ADD, OP_SUB: begin
              nEi = 1'b0;
              nLm = 1'b0;
            end
            OP_OUT: begin
              Ea  = 1'b1;
              nLo = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (op_q)
            OP_LDA: begin
              nCE = 1'b0;
              nLa = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              nCE = 1'b0;
              nLb = 1'b0;
              Su  = (op_q == OP_SUB);
            end
            default: ;
          endcase
        end
        T6: begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              Eu  = 1'b1;
              nLa = 1'b0;
              Su  = (op_q == OP_SUB);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

SAP-1 control sequencer. Consumes the 4-bit `opcode` produced by the instruction register and drives every active-low load/enable and active-high enable strobe in the datapath, including the IR's own `nLi` and `nEi`. A six-state ring counter (T1–T6) advances on the falling edge of `CLK`, so each control word is stable before the rising edge on which the datapath registers sample it.

## Interface
- No parameters. The opcode map is fixed: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. All other values are NOP.
- `CLK` in 1: system clock. The ring counter and opcode latch update on the negedge; the datapath samples on the posedge.
- `CLR` in 1: reset, asynchronous and active-high.
- `opcode` in 4: instruction opcode from the IR.
- `T` out 6: one-hot ring state, T1=6'b000001 … T6=6'b100000.
- `Cp` out 1: program counter increment (active-high).
- `Ep` out 1: PC drives the address bus (active-high).
- `nLm` out 1: MAR load (active-low).
- `nCE` out 1: RAM output enable (active-low).
- `nLi` out 1: IR load (active-low).
- `nEi` out 1: IR drives its address field (active-low).
- `nLa` out 1: accumulator load (active-low).
- `Ea` out 1: accumulator drives the bus (active-high).
- `Su` out 1: ALU subtract select (active-high).
- `Eu` out 1: ALU drives the bus (active-high).
- `nLb` out 1: B register load (active-low).
- `nLo` out 1: output register load (active-low).
- `HLT` out 1: halt flag (active-high). External logic gates the clock with it.

## Operation
- **State.** The block holds three pieces of state:
  - the ring register `T`;
  - a 4-bit opcode latch `op_q`;
  - a `halted` flag.
- **Control word.** The control word is a purely combinational decode of `T`, `op_q` and `halted`. Inactive levels are: active-high signals = 0, active-low signals = 1.
- **Fetch cycle** (identical for every opcode):
  - T1: `Ep=1`, `nLm=0`.
  - T2: `Cp=1`.
  - T3: `nCE=0`, `nLi=0`.
- **Execute cycle, LDA:**
  - T4: `nEi=0`, `nLm=0`.
  - T5: `nCE=0`, `nLa=0`.
  - T6: idle.
- **Execute cycle, ADD:**
  - T4: `nEi=0`, `nLm=0`.
  - T5: `nCE=0`, `nLb=0`.
  - T6: `Eu=1`, `nLa=0`.
- **Execute cycle, SUB:**
  - Same as ADD.
  - Additionally `Su=1` in T5 and T6, so the ALU result is settled before the T6 rising edge.
- **Execute cycle, OUT:**
  - T4: `Ea=1`, `nLo=0`.
  - T5 and T6: idle.
- **Execute cycle, NOP** (undefined opcodes): T4–T6 idle.
- **HLT:**
  - On the falling edge that enters T4 with a latched opcode of 4'hF, set `halted=1`.
  - While halted, `T` stays at T4, `HLT=1`, and every other output sits at its inactive level.
  - Only `CLR` leaves the halted state.
- **Opcode latch.** `op_q` captures `opcode` on the falling edge that moves T3→T4. It holds that value through T6, so IR changes outside T3 never disturb the execute cycle.
- **Ring advance.** The ring rotates T1→T2→…→T6→T1 on every falling edge, except when halted.

## Timing
- **Reset.** While `CLR`=1 (asynchronous, immediate effect, including mid-instruction or while halted):
  - `T=6'b000001`, `op_q=4'h0`, `halted=0`.
  - Outputs therefore equal the T1 word: `Ep=1`, `nLm=0`, every other strobe inactive, `HLT=0`.
- **Release from reset.** The first falling edge after `CLR` deasserts moves the ring to T2.
- **State length.** Each T-state lasts exactly one clock period, from falling edge to falling edge.
- **Output latency.** The control word changes combinationally after the falling edge. The consuming rising edge follows half a period later.
- **Instruction length.** Every instruction takes exactly 6 clocks. No state is skipped, even for NOP or OUT.
- **Opcode visibility.** The IR's `opcode` is valid from the rising edge inside T3. The T3→T4 falling edge latches it.
- **HLT entry.** `HLT` rises at the T3→T4 falling edge and stays high indefinitely. Further edges change no output.
- **CLR in halt.** Asserting `CLR` while halted drops `HLT` at once and restarts at T1.
- **Opcode changes mid-execute.** If `opcode` changes during T4–T6, the outputs are unaffected.

## Test plan
- **Reset.** Assert `CLR` mid-T5 of an ADD → outputs immediately become `T=000001`, `Ep=1`, `nLm=0`, all others inactive. After release, 6 falling edges return to `T=000001`.
- **LDA.** `opcode=4'h0` held → T1..T6 words match the LDA table exactly. `nLi=0` only in T3. `nEi=0` only in T4. Pattern repeats every 6 clocks.
- **SUB.** `opcode=4'h2` → `Su=1` in T5 and T6 only. `Eu=1` and `nLa=0` together only in T6. `nLb=0` only in T5.
- **Opcode latch.** `opcode=4'h1` at the T3→T4 edge, then changed to 4'hE during T5 → T6 still gives `Eu=1`, `nLa=0`, and `nLo` stays 1.
- **HLT.** `opcode=4'hF` → `HLT=1` at the T4 entry, `T` frozen at 6'b001000 for 20 clocks with all strobes inactive. Asserting `CLR` → `HLT=0`, `T=000001`.
- **NOP.** `opcode=4'h7` → T4–T6 all strobes inactive, `HLT=0`, and the next fetch starts at T1 on schedule.
